// File: rtl/clear_array_rf.sv
// Register-file array with a sequential bulk-clear engine sweeping
// CLR_PER_CYC entries per cycle; reset runs the same sweep automatically.
module clear_array_rf #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       DEPTH       = 256,
    parameter int unsigned       ADDR_W      = $clog2(DEPTH),
    parameter int unsigned       CLR_PER_CYC = 4,
    parameter logic [DATA_W-1:0] CLR_VAL     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int unsigned CLR_LOG = $clog2(CLR_PER_CYC);
    localparam int unsigned PTR_W   = (ADDR_W > CLR_LOG) ? ADDR_W - CLR_LOG : 1;
    localparam int unsigned LANE_W  = (CLR_LOG > 0) ? CLR_LOG : 1;
    localparam int unsigned GROUPS  = DEPTH / CLR_PER_CYC;
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(GROUPS - 1);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(CLR_PER_CYC - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [PTR_W-1:0]    clr_ptr;
    logic [PTR_W-1:0]    clr_ptr_d;
    logic                clr_done_d;

    // Storage organised as groups so one sweep cycle writes a whole group row
    logic [CLR_PER_CYC-1:0][DATA_W-1:0] mem [GROUPS];

    logic [PTR_W-1:0]  wr_group;
    logic [LANE_W-1:0] wr_lane;
    logic [PTR_W-1:0]  rd_group;
    logic [LANE_W-1:0] rd_lane;

    assign wr_group = PTR_W'(wr_addr >> CLR_LOG);
    assign wr_lane  = LANE_W'(wr_addr & LANE_MASK);
    assign rd_group = PTR_W'(rd_addr >> CLR_LOG);
    assign rd_lane  = LANE_W'(rd_addr & LANE_MASK);

    assign clr_busy = (state == CLEAR);
    assign wr_ready = ~clr_busy;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_d;
            clr_ptr  <= clr_ptr_d;
            clr_done <= clr_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state;
        clr_ptr_d  = clr_ptr;
        clr_done_d = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                if (clr_ptr == LAST_PTR) begin
                    state_d    = IDLE;
                    clr_ptr_d  = '0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_ptr_d = clr_ptr + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Array storage: sweep owns the array while clearing, write port otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= {CLR_PER_CYC{CLR_VAL}};
            end else if (wr_en) begin
                mem[wr_group][wr_lane] <= wr_data;
            end
        end
    end

    // Registered read port; reads during a sweep report the clear value
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= (state == CLEAR) ? CLR_VAL : mem[rd_group][rd_lane];
            end
        end
    end

endmodule

// File: tb/tb_clear_array_rf.sv
// Directed self-checking bench for clear_array_rf: default instance plus a
// 16-entry, one-entry-per-cycle instance with a non-zero clear value.
module tb_clear_array_rf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance
    logic       reset, clr_req, clr_busy, clr_done;
    logic       wr_en, wr_ready, rd_en, rd_valid;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

    // Parameter-sweep instance
    logic        reset2, clr_req2, clr_busy2, clr_done2;
    logic        wr_en2, wr_ready2, rd_en2, rd_valid2;
    logic [3:0]  wr_addr2, rd_addr2;
    logic [15:0] wr_data2, rd_data2;

    clear_array_rf dut (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    clear_array_rf #(
        .DATA_W      (16),
        .DEPTH       (16),
        .CLR_PER_CYC (1),
        .CLR_VAL     (16'hBEEF)
    ) dut2 (
        .clk      (clk),
        .reset    (reset2),
        .clr_req  (clr_req2),
        .clr_busy (clr_busy2),
        .clr_done (clr_done2),
        .wr_en    (wr_en2),
        .wr_addr  (wr_addr2),
        .wr_data  (wr_data2),
        .wr_ready (wr_ready2),
        .rd_en    (rd_en2),
        .rd_addr  (rd_addr2),
        .rd_data  (rd_data2),
        .rd_valid (rd_valid2)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic v);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       v;
        int         cnt;
        logic [7:0] addrs [3];
        addrs[0] = 8'd0; addrs[1] = 8'd127; addrs[2] = 8'd255;
        reset = 1'b1;
        rd_en = 1'b1; rd_addr = 8'd3;
        repeat (3) tick();
        checks++;
        if (clr_busy !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 ||
            rd_data !== 8'h00 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b ready=%b rv=%b rd=%h done=%b, expected 1 0 0 00 0",
                     clr_busy, wr_ready, rd_valid, rd_data, clr_done);
        end
        rd_en = 1'b0;
        reset = 1'b0;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 64 || clr_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_sweep_len: busy cycles=%0d done=%b, expected 64 and 1", cnt, clr_done);
        end
        tick();
        checks++;
        if (clr_done !== 1'b0 || clr_busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_done_pulse: done=%b busy=%b ready=%b, expected 0 0 1",
                     clr_done, clr_busy, wr_ready);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(addrs[i], d, v);
            checks++;
            if (d !== 8'h00 || v !== 1'b1) begin
                errors++;
                $display("FAIL reset_read[%0d]: data=%h valid=%b, expected 00 1", addrs[i], d, v);
            end
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_drop: got %b expected 0", rd_valid);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] d;
        logic       v;
        do_write(8'd5, 8'h32);
        do_read(8'd5, d, v);
        checks++;
        if (d !== 8'h32 || v !== 1'b1) begin
            errors++;
            $display("FAIL write_read: data=%h valid=%b, expected 32 1", d, v);
        end
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'h44;
        rd_en = 1'b1; rd_addr = 8'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'h32 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_before_write: data=%h valid=%b, expected 32 1", rd_data, rd_valid);
        end
        tick();
        checks++;
        if (rd_data !== 8'h32 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_hold: data=%h valid=%b, expected 32 0", rd_data, rd_valid);
        end
        do_read(8'd5, d, v);
        checks++;
        if (d !== 8'h44) begin
            errors++;
            $display("FAIL write_after_collision: got %h expected 44", d);
        end
    endtask

    task automatic test_fill_clear();
        logic [7:0] d;
        logic       v;
        logic [7:0] spot [3];
        int         cnt;
        int         bad;
        spot[0] = 8'h00; spot[1] = 8'h5A; spot[2] = 8'hFF;
        for (int a = 0; a < 256; a++) do_write(8'(a), 8'(a) ^ 8'hA5);
        for (int i = 0; i < 3; i++) begin
            do_read(spot[i], d, v);
            checks++;
            if (d !== (spot[i] ^ 8'hA5)) begin
                errors++;
                $display("FAIL fill_read[%0h]: got %h expected %h", spot[i], d, spot[i] ^ 8'hA5);
            end
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        while (wr_ready === 1'b0 && cnt < 200) begin
            cnt++;
            wr_en = 1'b1; wr_addr = 8'(cnt * 3); wr_data = 8'h55;
            tick();
        end
        wr_en = 1'b0;
        checks++;
        if (cnt != 64 || clr_done !== 1'b1) begin
            errors++;
            $display("FAIL clear_window: ready-low cycles=%0d done=%b, expected 64 and 1", cnt, clr_done);
        end
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            do_read(8'(a), d, v);
            if (d !== 8'h00) begin
                bad++;
                if (bad <= 4) $display("FAIL cleared_entry[%0d]: got %h expected 00", a, d);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cleared_array: %0d entries non-zero, expected 0", bad);
        end
    endtask

    task automatic test_clr_with_write();
        logic [7:0] d;
        logic       v;
        int         cnt;
        wr_en = 1'b1; wr_addr = 8'd9; wr_data = 8'h7F;
        clr_req = 1'b1;
        tick();
        wr_en = 1'b0; clr_req = 1'b0;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 200) begin
            cnt++;
            clr_req = (cnt == 10 || cnt == 64);
            tick();
        end
        clr_req = 1'b0;
        checks++;
        if (cnt != 64 || clr_done !== 1'b1) begin
            errors++;
            $display("FAIL clr_req_ignored: busy cycles=%0d done=%b, expected 64 and 1", cnt, clr_done);
        end
        tick();
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL no_restart: busy=%b done=%b, expected 0 0", clr_busy, clr_done);
        end
        do_read(8'd9, d, v);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL write_then_clear: got %h expected 00", d);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int   cnt;
        logic done_seen;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (30) tick();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if (clr_busy !== 1'b1 || clr_done !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b ready=%b, expected 1 0 0",
                     clr_busy, clr_done, wr_ready);
        end
        reset = 1'b0;
        cnt = 0;
        done_seen = 1'b0;
        while (clr_busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (clr_done === 1'b1) done_seen = 1'b1;
            tick();
        end
        checks++;
        if (cnt != 64 || done_seen !== 1'b0 || clr_done !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_restart: busy cycles=%0d early_done=%b done=%b, expected 64 0 1",
                     cnt, done_seen, clr_done);
        end
    endtask

    task automatic test_param();
        int cnt;
        int bad;
        tick();
        reset2 = 1'b0;
        cnt = 0;
        bad = 0;
        while (clr_busy2 === 1'b1 && cnt < 100) begin
            rd_en2 = 1'b1; rd_addr2 = 4'(cnt);
            cnt++;
            tick();
            if (rd_valid2 !== 1'b1 || rd_data2 !== 16'hBEEF) bad++;
        end
        rd_en2 = 1'b0;
        checks++;
        if (cnt != 16 || clr_done2 !== 1'b1) begin
            errors++;
            $display("FAIL p_sweep_len: busy cycles=%0d done=%b, expected 16 and 1", cnt, clr_done2);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL p_read_during_sweep: %0d reads not BEEF, expected 0", bad);
        end
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            rd_en2 = 1'b1; rd_addr2 = 4'(a);
            tick();
            rd_en2 = 1'b0;
            if (rd_data2 !== 16'hBEEF) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL p_cleared_array: %0d entries not BEEF, expected 0", bad);
        end
        wr_en2 = 1'b1; wr_addr2 = 4'd7; wr_data2 = 16'h1234;
        tick();
        wr_en2 = 1'b0;
        rd_en2 = 1'b1; rd_addr2 = 4'd7;
        tick();
        rd_en2 = 1'b0;
        checks++;
        if (rd_data2 !== 16'h1234) begin
            errors++;
            $display("FAIL p_write_read: got %h expected 1234", rd_data2);
        end
    endtask

    initial begin
        reset = 1'b1; clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        reset2 = 1'b1; clr_req2 = 1'b0; wr_en2 = 1'b0; rd_en2 = 1'b0;
        wr_addr2 = '0; wr_data2 = '0; rd_addr2 = '0;
        tick();
        test_reset();
        test_write_read();
        test_fill_clear();
        test_clr_with_write();
        test_reset_mid_sweep();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clear_array_rf.md
# clear_array_rf

Parametrised single-clock register-file array with a built-in sequential bulk-clear engine. A clear takes DEPTH/CLR_PER_CYC cycles. It replaces the single-cycle full-array clear loop used in earlier array blocks. The block supports one write port, one registered read port, and a software-requested clear. Reset also runs the clear automatically. It sits between the datapath that fills the table, for example the `in_tmp` index-write producer, and downstream readers.

## Interface
- DATA_W, 8: width of each array entry.
- DEPTH, 256: number of entries; must be a multiple of CLR_PER_CYC and a power of two.
- ADDR_W, $clog2(DEPTH): address width.
- CLR_PER_CYC, 4: entries cleared per sweep cycle; must be a power of two, 1..DEPTH.
- CLR_VAL, 0: value, DATA_W wide, written to every entry by a clear.
- clk  in  1  single clock; all logic runs on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clr_req  in  1  single-cycle request to start a clear sweep.
- clr_busy  out  1  high while a sweep is in progress.
- clr_done  out  1  one-cycle pulse in the cycle after the last group is cleared.
- wr_en  in  1  write strobe; only honoured when wr_ready=1.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  equal to ~clr_busy (combinational from state only, no input path).
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  registered; high in the cycle after an accepted rd_en.

## Operation
- State machine with two states, IDLE and CLEAR, plus a group pointer clr_ptr of width ADDR_W-$clog2(CLR_PER_CYC), with a minimum width of 1.
- Reset, when sampled high:
  - state is set to CLEAR and clr_ptr to 0.
  - rd_valid, rd_data and clr_done are set to 0.
  - No array writes occur.
  - The array storage itself is not reset; only the sweep initialises it.
- Outputs while reset is held: clr_busy=1, wr_ready=0, rd_valid=0, rd_data=0, clr_done=0.
- IDLE:
  - An accepted write (wr_en) stores wr_data at wr_addr.
  - clr_req moves the FSM to CLEAR with clr_ptr=0.
  - If wr_en and clr_req arrive together, the write is performed. The sweep then overwrites that entry with CLR_VAL.
- CLEAR:
  - Each edge writes CLR_VAL to entries clr_ptr*CLR_PER_CYC .. clr_ptr*CLR_PER_CYC+CLR_PER_CYC-1, then increments clr_ptr.
  - On the edge that clears the last group (clr_ptr = DEPTH/CLR_PER_CYC-1): clr_ptr wraps to 0, state goes to IDLE and clr_done is set for one cycle.
- During CLEAR:
  - wr_en is dropped; the array is unchanged by the write port.
  - clr_req is ignored; a sweep is never restarted or extended.
- Reads:
  - rd_en is accepted in any non-reset cycle.
  - In IDLE, rd_data is the array value at rd_addr as of before that edge's write (read-before-write on an address collision).
  - In CLEAR, rd_data is CLR_VAL regardless of sweep progress.
- rd_data holds its last value when rd_en=0. rd_valid then drops to 0.
- Reset asserted mid-sweep restarts the sweep from clr_ptr=0. No clr_done is issued for the aborted sweep.

## Timing
- G = DEPTH/CLR_PER_CYC sweep cycles (G=64 at defaults).
- clr_req sampled at edge N:
  - groups 0..G-1 are cleared at edges N+1..N+G.
  - clr_busy is high from after N until after N+G.
  - clr_done is high between edges N+G and N+G+1.
- Reset:
  - Let R be the first edge with reset=0. Groups are cleared at edges R..R+G-1.
  - clr_busy falls after R+G-1.
  - clr_done pulses for the cycle after R+G-1.
- Write latency: a write at edge N is visible to a read sampled at edge N+1.
- Read latency: 1 cycle. rd_en at edge N gives rd_data/rd_valid valid after N.
- Back-to-back clr_req on the edge where clr_done would assert: the FSM is in CLEAR at that edge, so the request is ignored.

## Test plan
- Reset held 3 cycles, then released:
  - clr_busy=1 for exactly 64 cycles, then clr_done pulses once.
  - Reads at addresses 0, 127 and 255 return 0x00 with rd_valid one cycle after rd_en.
- In IDLE, write 0x32 at addr 5, then read addr 5 on the next cycle: rd_data=0x32 one cycle after rd_en. A same-cycle read/write to addr 5 with 0x44 returns 0x32; the next read returns 0x44.
- Fill all 256 entries with addr^0xA5, then pulse clr_req:
  - wr_ready is low for 64 cycles.
  - Writes attempted during that window are dropped.
  - After clr_done, every entry reads 0x00.
- clr_req with wr_en (addr 9, 0x7F) on the same edge: after the sweep, addr 9 reads 0x00. A second clr_req mid-sweep does not extend clr_busy beyond 64 cycles.
- Reset asserted at sweep cycle 30: the sweep restarts from 0, there is no clr_done for the aborted sweep, and clr_done fires 64 cycles after reset release.
- Parameter sweep with DATA_W=16, DEPTH=16, CLR_PER_CYC=1 and CLR_VAL=0xBEEF:
  - clr_busy lasts 16 cycles.
  - All entries read 0xBEEF afterwards.
  - Reads during the sweep return 0xBEEF.
